systolic_seq_ctrl: RTL

Sequencer for an R x C output-stationary systolic array. Runs one tile per `start` through four phases:
- load K-deep operand vectors into the per-lane X/W FIFOs;
- stream them out with diagonal skew;
- drain the PE pipeline;
- hand the result rows to the writeback path.

Successor to the fixed-size load/mac/out controller. Adds runtime K, separate array dimensions, skewed read enables, a drain phase, an output handshake, and a done pulse.

---
 rtl/systolic_seq_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for an output-stationary R x C systolic array.
// One tile per accepted start: LOAD operand vectors into the per-lane
// FIFOs, MAC with diagonally skewed reads, DRAIN the PE pipeline, then
// hand result rows to writeback one at a time under a val/rdy handshake.
module systolic_seq_ctrl #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DEPTH = 16,
  parameter int KW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      acc_clr,
  output logic                      mac_en,
  input  logic                      x_send_val,
  output logic                      x_send_rdy,
  input  logic                      w_send_val,
  output logic                      w_send_rdy,
  output logic [ROWS-1:0]           x_fifo_wen,
  output logic [ROWS-1:0]           x_fifo_ren,
  output logic [COLS-1:0]           w_fifo_wen,
  output logic [COLS-1:0]           w_fifo_ren,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [$clog2(ROWS)-1:0]   out_row_sel
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  // Phase counter must cover both the MAC length and the DRAIN length.
  localparam int CW    = $clog2(DEPTH + ROWS + COLS + 1);
  localparam int RW    = $clog2(ROWS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [KW-1:0] K_MAX      = KW'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] xc_q, xc_d;
  logic [KW-1:0] wc_q, wc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] r_q, r_d;
  logic          done_q, done_d;
  logic          clr_q, clr_d;

  logic [KW-1:0] k_eff;
  logic [CW-1:0] mac_last;
  logic          x_hs, w_hs, out_hs;

  // K is clamped to the FIFO depth; the last MAC cycle index is K + max(R,C) - 2.
  assign k_eff    = (k_len > K_MAX) ? K_MAX : k_len;
  assign mac_last = CW'(k_q) + CW'(MAXRC - 2);

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign acc_clr     = clr_q;
  assign mac_en      = (state_q == S_MAC) || (state_q == S_DRAIN);
  assign x_send_rdy  = (state_q == S_LOAD) && (xc_q < k_q);
  assign w_send_rdy  = (state_q == S_LOAD) && (wc_q < k_q);
  assign x_hs        = x_send_val & x_send_rdy;
  assign w_hs        = w_send_val & w_send_rdy;
  assign x_fifo_wen  = {ROWS{x_hs}};
  assign w_fifo_wen  = {COLS{w_hs}};
  assign out_val     = (state_q == S_OUT);
  assign out_hs      = out_val & out_rdy;
  assign out_row_sel = out_val ? r_q : '0;

  // Skewed read enables: lane n reads during MAC cycles n .. n+K-1.
  always_comb begin
    x_fifo_ren = '0;
    w_fifo_ren = '0;
    if (state_q == S_MAC) begin
      for (int i = 0; i < ROWS; i++)
        x_fifo_ren[i] = (cnt_q >= CW'(i)) && (cnt_q < CW'(i) + CW'(k_q));
      for (int j = 0; j < COLS; j++)
        w_fifo_ren[j] = (cnt_q >= CW'(j)) && (cnt_q < CW'(j) + CW'(k_q));
    end
  end

  // Next-state logic for the phase FSM and its counters.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xc_d    = xc_q;
    wc_d    = wc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (k_eff != '0)) begin
          state_d = S_LOAD;
          k_d     = k_eff;
          xc_d    = '0;
          wc_d    = '0;
          clr_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (x_hs) xc_d = xc_q + 1'b1;
        if (w_hs) wc_d = wc_q + 1'b1;
        // Leave only once both counts were already full at the start of this cycle.
        if ((xc_q == k_q) && (wc_q == k_q)) begin
          state_d = S_MAC;
          cnt_d   = '0;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == mac_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_OUT;
          cnt_d   = '0;
          r_d     = '0;
        end
      end
      S_OUT: begin
        if (out_hs) begin
          if (r_q == ROW_LAST) begin
            state_d = S_IDLE;
            r_d     = '0;
            done_d  = 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      xc_q    <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xc_q    <= xc_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

endmodule
